// File: rtl/cla_pkg.sv
// Shared constants and types for the 32-bit carry-lookahead adder.
// Group width, group count and the 4-bit group p/g vector type.
package cla_pkg;

   localparam int CLA_WIDTH   = 32;
   localparam int CLA_GROUP   = 4;
   localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;

   typedef logic [CLA_GROUP-1:0] grp_vec_t;

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead group: sum bits plus group propagate/generate.
// Ports: a, b, cin in; sum, grp_p, grp_g out.
module cla4
   import cla_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       grp_p,
   output logic       grp_g
);

   grp_vec_t p;
   grp_vec_t g;
   grp_vec_t c;

   assign g = a & b;
   assign p = a ^ b;

   // Every internal carry is a flat sum of products on cin.
   assign c[0] = cin;
   assign c[1] = g[0]
               | (p[0] & cin);
   assign c[2] = g[1]
               | (p[1] & g[0])
               | (p[1] & p[0] & cin);
   assign c[3] = g[2]
               | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);

   assign sum = p ^ c;

   assign grp_p = &p;
   assign grp_g = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

endmodule

// File: rtl/cla32_adder.sv
// Registered 32-bit two-level carry-lookahead adder: {c32,s} = a + b + c0.
// Ports: clk, rst (sync, active high), a, b, c0 in; s, c32, ovf out.
// ovf port and overflow logic exist only when CLA32_OVF_EN is defined.
module cla32_adder
   import cla_pkg::*;
#(
   parameter int WIDTH = CLA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c0,
   output logic [WIDTH-1:0] s,
`ifdef CLA32_OVF_EN
   output logic             ovf,
`endif
   output logic             c32
);

   logic [CLA_NGROUPS-1:0] gp;
   logic [CLA_NGROUPS-1:0] gg;
   logic [CLA_NGROUPS:0]   cg;
   logic [CLA_WIDTH-1:0]   sum;

   genvar k;
   generate
      for (k = 0; k < CLA_NGROUPS; k++) begin : g_grp
         cla4 u_grp (
            .a     (a[CLA_GROUP*k +: CLA_GROUP]),
            .b     (b[CLA_GROUP*k +: CLA_GROUP]),
            .cin   (cg[k]),
            .sum   (sum[CLA_GROUP*k +: CLA_GROUP]),
            .grp_p (gp[k]),
            .grp_g (gg[k])
         );
      end
   endgenerate

   // Level-2 lookahead: cg[k] is the carry into group k (c0, c4 ... c32),
   // each fully expanded so no group waits on its neighbour.
   assign cg[0] = c0;
   assign cg[1] = gg[0]
                | (gp[0] & c0);
   assign cg[2] = gg[1]
                | (gp[1] & gg[0])
                | ((&gp[1:0]) & c0);
   assign cg[3] = gg[2]
                | (gp[2] & gg[1])
                | ((&gp[2:1]) & gg[0])
                | ((&gp[2:0]) & c0);
   assign cg[4] = gg[3]
                | (gp[3] & gg[2])
                | ((&gp[3:2]) & gg[1])
                | ((&gp[3:1]) & gg[0])
                | ((&gp[3:0]) & c0);
   assign cg[5] = gg[4]
                | (gp[4] & gg[3])
                | ((&gp[4:3]) & gg[2])
                | ((&gp[4:2]) & gg[1])
                | ((&gp[4:1]) & gg[0])
                | ((&gp[4:0]) & c0);
   assign cg[6] = gg[5]
                | (gp[5] & gg[4])
                | ((&gp[5:4]) & gg[3])
                | ((&gp[5:3]) & gg[2])
                | ((&gp[5:2]) & gg[1])
                | ((&gp[5:1]) & gg[0])
                | ((&gp[5:0]) & c0);
   assign cg[7] = gg[6]
                | (gp[6] & gg[5])
                | ((&gp[6:5]) & gg[4])
                | ((&gp[6:4]) & gg[3])
                | ((&gp[6:3]) & gg[2])
                | ((&gp[6:2]) & gg[1])
                | ((&gp[6:1]) & gg[0])
                | ((&gp[6:0]) & c0);
   assign cg[8] = gg[7]
                | (gp[7] & gg[6])
                | ((&gp[7:6]) & gg[5])
                | ((&gp[7:5]) & gg[4])
                | ((&gp[7:4]) & gg[3])
                | ((&gp[7:3]) & gg[2])
                | ((&gp[7:2]) & gg[1])
                | ((&gp[7:1]) & gg[0])
                | ((&gp[7:0]) & c0);

`ifdef CLA32_OVF_EN
   logic c31;
   logic ovf_next;

   // Carry into bit 31 recovered from its sum bit: s31 = a31 ^ b31 ^ c31.
   assign c31      = sum[31] ^ a[31] ^ b[31];
   assign ovf_next = cg[8] ^ c31;

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf <= 1'b0;
      end else begin
         ovf <= ovf_next;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         s   <= '0;
         c32 <= 1'b0;
      end else begin
         s   <= sum;
         c32 <= cg[8];
      end
   end

endmodule

// File: tb/tb_cla32_adder.sv
// Scoreboard bench for cla32_adder: directed vectors plus a random run.
// Ovf checks apply when CLA32_OVF_EN is defined.
module tb_cla32_adder;

   typedef struct {
      logic [31:0] s;
      logic        c32;
      logic        ovf;
      string       name;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] a;
   logic [31:0] b;
   logic        c0;
   logic [31:0] s;
   logic        c32;
   logic        ovf_dut;

   int compared;
   int mismatched;
   exp_t sb[$];

   cla32_adder #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .a   (a),
      .b   (b),
      .c0  (c0),
      .s   (s),
`ifdef CLA32_OVF_EN
      .ovf (ovf_dut),
`endif
      .c32 (c32)
   );

`ifndef CLA32_OVF_EN
   assign ovf_dut = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change on the falling edge; the next rising edge captures them.
   task automatic issue(input logic r,
                        input logic [31:0] va,
                        input logic [31:0] vb,
                        input logic vc,
                        input logic [31:0] es,
                        input logic ec,
                        input logic eo,
                        input string nm);
      exp_t e;
      @(negedge clk);
      rst = r;
      a   = va;
      b   = vb;
      c0  = vc;
      e.s    = es;
      e.c32  = ec;
      e.ovf  = eo;
      e.name = nm;
      sb.push_back(e);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         compared++;
         if ({c32, s} !== {e.c32, e.s}) begin
            mismatched++;
            $display("FAIL %s: got c32=%b s=%h, want c32=%b s=%h",
                     e.name, c32, s, e.c32, e.s);
         end
`ifdef CLA32_OVF_EN
         if (ovf_dut !== e.ovf) begin
            mismatched++;
            $display("FAIL %s ovf: got %b, want %b",
                     e.name, ovf_dut, e.ovf);
         end
`endif
      end
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      logic [32:0] rsum;
      logic        rov;
      compared   = 0;
      mismatched = 0;
      rst = 1'b1;
      a   = '0;
      b   = '0;
      c0  = 1'b0;

      issue(1, 32'hFFFFFFFF, 32'h1, 1, 32'h0, 0, 0, "reset");
      issue(0, 32'hFFFFFFFF, 32'h1, 1, 32'h1, 1, 0, "rst_release");

      issue(0, 32'h0, 32'h0, 0, 32'h0,  0, 0, "b0");
      issue(0, 32'h1, 32'h0, 0, 32'h1,  0, 0, "b1");
      issue(0, 32'h1, 32'h1, 0, 32'h2,  0, 0, "b2");
      issue(0, 32'h1, 32'h1, 1, 32'h3,  0, 0, "b3");
      issue(0, 32'hF, 32'h1, 0, 32'h10, 0, 0, "b4");
      issue(0, 32'hF, 32'hF, 0, 32'h1E, 0, 0, "b5");
      issue(0, 32'hF, 32'hF, 1, 32'h1F, 0, 0, "b6");
      issue(0, 32'hF, 32'hF, 1, 32'h1F, 0, 0, "hold");

      issue(0, 32'hFFFFFFFF, 32'h0, 1, 32'h0, 1, 0, "chain");

      issue(0, 32'h0000000F, 32'h1, 0, 32'h00000010, 0, 0, "grp1");
      issue(0, 32'h000000FF, 32'h1, 0, 32'h00000100, 0, 0, "grp2");
      issue(0, 32'h00000FFF, 32'h1, 0, 32'h00001000, 0, 0, "grp3");
      issue(0, 32'h0000FFFF, 32'h1, 0, 32'h00010000, 0, 0, "grp4");
      issue(0, 32'h000FFFFF, 32'h1, 0, 32'h00100000, 0, 0, "grp5");
      issue(0, 32'h00FFFFFF, 32'h1, 0, 32'h01000000, 0, 0, "grp6");
      issue(0, 32'h0FFFFFFF, 32'h1, 0, 32'h10000000, 0, 0, "grp7");

      issue(0, 32'h7FFFFFFF, 32'h1, 0, 32'h80000000, 0, 1, "ovf_pos");
      issue(0, 32'h80000000, 32'h80000000, 0, 32'h0, 1, 1, "ovf_neg");
      issue(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 32'hFFFFFFFE, 1, 0, "neg_ok");

      issue(1, 32'h12345678, 32'h11111111, 1, 32'h0, 0, 0, "mid_rst");
      issue(0, 32'h12345678, 32'h11111111, 1, 32'h2345678A, 0, 0, "post_rst");

      for (int i = 0; i < 2000; i++) begin
         ra   = $urandom;
         rb   = $urandom;
         rc   = 1'($urandom_range(0, 1));
         rsum = {1'b0, ra} + {1'b0, rb} + {32'h0, rc};
         rov  = (ra[31] == rb[31]) && (rsum[31] != ra[31]);
         issue(0, ra, rb, rc, rsum[31:0], rsum[32], rov, "rand");
      end

      for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
      #2;
      if (sb.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d pending, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
